// File: rtl/id_ex_stage_if.sv
// Handshake and payload bundle between decode and the id_ex_stage pipeline register.
// "slave" is the stage itself; "master" is whoever drives decode inputs and the execute-side ready.
interface id_ex_stage_if #(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
);
    logic               i_valid;
    logic               o_ready;
    logic [XLEN-1:0]    i_rs1_data;
    logic [XLEN-1:0]    i_rs2_data;
    logic [XLEN-1:0]    i_imm;
    logic               i_alu_src;
    logic [1:0]         i_alu_op;
    logic [2:0]         i_funct3;
    logic               i_funct7_5;
    logic [RADDR_W-1:0] i_rd;
    logic               i_reg_write;
    logic               i_mem_read;
    logic               i_mem_write;
    logic               i_branch;
    logic               i_flush;
    logic               o_valid;
    logic               i_ready;
    logic [3:0]         o_alu_control;
    logic [XLEN-1:0]    o_alu_a;
    logic [XLEN-1:0]    o_alu_b;
    logic [XLEN-1:0]    o_store_data;
    logic [RADDR_W-1:0] o_rd;
    logic               o_reg_write;
    logic               o_mem_read;
    logic               o_mem_write;
    logic               o_branch;
    logic               o_illegal;
    logic [CNT_W-1:0]   o_stall_cnt;

    modport slave (
        input  i_valid, i_rs1_data, i_rs2_data, i_imm, i_alu_src, i_alu_op,
               i_funct3, i_funct7_5, i_rd, i_reg_write, i_mem_read, i_mem_write,
               i_branch, i_flush, i_ready,
        output o_ready, o_valid, o_alu_control, o_alu_a, o_alu_b, o_store_data,
               o_rd, o_reg_write, o_mem_read, o_mem_write, o_branch, o_illegal,
               o_stall_cnt
    );

    modport master (
        output i_valid, i_rs1_data, i_rs2_data, i_imm, i_alu_src, i_alu_op,
               i_funct3, i_funct7_5, i_rd, i_reg_write, i_mem_read, i_mem_write,
               i_branch, i_flush, i_ready,
        input  o_ready, o_valid, o_alu_control, o_alu_a, o_alu_b, o_store_data,
               o_rd, o_reg_write, o_mem_read, o_mem_write, o_branch, o_illegal,
               o_stall_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: valid/ready handshake, ALU control decode, operand-B select,
// flush of the held entry and a saturating stall counter.
module id_ex_stage #(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    id_ex_stage_if.slave  bus
);

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_BAD = 4'b1111
    } alu_ctl_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               valid_q;
    logic               load;
    alu_ctl_e           alu_ctl_d;
    alu_ctl_e           alu_ctl_q;
    logic               illegal_d;
    logic               illegal_q;
    logic [XLEN-1:0]    op_b_d;
    logic [XLEN-1:0]    alu_a_q;
    logic [XLEN-1:0]    alu_b_q;
    logic [XLEN-1:0]    store_q;
    logic [RADDR_W-1:0] rd_q;
    logic               reg_write_q;
    logic               mem_read_q;
    logic               mem_write_q;
    logic               branch_q;
    logic [CNT_W-1:0]   stall_cnt_q;

    assign bus.o_ready = !valid_q || bus.i_ready;
    assign load        = bus.i_valid && bus.o_ready && !bus.i_flush;
    assign op_b_d      = bus.i_alu_src ? bus.i_imm : bus.i_rs2_data;

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        alu_ctl_d = ALU_BAD;
        illegal_d = 1'b1;
        unique case (bus.i_alu_op)
            2'b00: begin alu_ctl_d = ALU_ADD; illegal_d = 1'b0; end
            2'b01: begin alu_ctl_d = ALU_SUB; illegal_d = 1'b0; end
            2'b10: begin
                unique case (bus.i_funct3)
                    3'b000: begin
                        // Immediate forms have no subtract; bit 30 is part of the immediate there.
                        alu_ctl_d = (bus.i_funct7_5 && !bus.i_alu_src) ? ALU_SUB : ALU_ADD;
                        illegal_d = 1'b0;
                    end
                    3'b111:  begin alu_ctl_d = ALU_AND; illegal_d = 1'b0; end
                    3'b110:  begin alu_ctl_d = ALU_OR;  illegal_d = 1'b0; end
                    default: begin alu_ctl_d = ALU_BAD; illegal_d = 1'b1; end
                endcase
            end
            default: begin alu_ctl_d = ALU_BAD; illegal_d = 1'b1; end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q     <= 1'b0;
            alu_ctl_q   <= ALU_AND;
            illegal_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            store_q     <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
        end else if (bus.i_flush) begin
            // Side-effecting controls are killed; datapath values are left as they were.
            valid_q     <= 1'b0;
            illegal_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
        end else if (load) begin
            valid_q     <= 1'b1;
            alu_ctl_q   <= alu_ctl_d;
            illegal_q   <= illegal_d;
            alu_a_q     <= bus.i_rs1_data;
            alu_b_q     <= op_b_d;
            store_q     <= bus.i_rs2_data;
            rd_q        <= bus.i_rd;
            reg_write_q <= bus.i_reg_write;
            mem_read_q  <= bus.i_mem_read;
            mem_write_q <= bus.i_mem_write;
            branch_q    <= bus.i_branch;
        end else if (valid_q && bus.i_ready) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
        end else if (valid_q && !bus.i_ready && !bus.i_flush && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus.o_valid       = valid_q;
    assign bus.o_alu_control = alu_ctl_q;
    assign bus.o_illegal     = illegal_q;
    assign bus.o_alu_a       = alu_a_q;
    assign bus.o_alu_b       = alu_b_q;
    assign bus.o_store_data  = store_q;
    assign bus.o_rd          = rd_q;
    assign bus.o_reg_write   = reg_write_q;
    assign bus.o_mem_read    = mem_read_q;
    assign bus.o_mem_write   = mem_write_q;
    assign bus.o_branch      = branch_q;
    assign bus.o_stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios then random traffic against a
// behavioural model; a second instance with a 2-bit stall counter shares the same stimulus.
module tb_id_ex_stage;

    localparam int XLEN    = 64;
    localparam int RADDR_W = 5;

    logic clk;
    logic rst_n;

    id_ex_stage_if #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(16)) bus_a ();
    id_ex_stage_if #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(2))  bus_b ();

    id_ex_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(16)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a.slave)
    );
    id_ex_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b.slave)
    );

    assign bus_b.i_valid     = bus_a.i_valid;
    assign bus_b.i_rs1_data  = bus_a.i_rs1_data;
    assign bus_b.i_rs2_data  = bus_a.i_rs2_data;
    assign bus_b.i_imm       = bus_a.i_imm;
    assign bus_b.i_alu_src   = bus_a.i_alu_src;
    assign bus_b.i_alu_op    = bus_a.i_alu_op;
    assign bus_b.i_funct3    = bus_a.i_funct3;
    assign bus_b.i_funct7_5  = bus_a.i_funct7_5;
    assign bus_b.i_rd        = bus_a.i_rd;
    assign bus_b.i_reg_write = bus_a.i_reg_write;
    assign bus_b.i_mem_read  = bus_a.i_mem_read;
    assign bus_b.i_mem_write = bus_a.i_mem_write;
    assign bus_b.i_branch    = bus_a.i_branch;
    assign bus_b.i_flush     = bus_a.i_flush;
    assign bus_b.i_ready     = bus_a.i_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state of the held entry.
    logic        m_valid;
    logic [3:0]  m_ctl;
    logic [63:0] m_a, m_b, m_st;
    logic [4:0]  m_rd;
    logic        m_rw, m_mr, m_mw, m_br, m_ill;
    int          m_cnt, m_cnt_s;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_ctl(input logic [1:0] op, input logic [2:0] f3,
                                           input logic f7, input logic src);
        if (op == 2'd0) return 4'd2;
        if (op == 2'd1) return 4'd6;
        if (op == 2'd3) return 4'd15;
        if (f3 == 3'd0) return (f7 && !src) ? 4'd6 : 4'd2;
        if (f3 == 3'd7) return 4'd0;
        if (f3 == 3'd6) return 4'd1;
        return 4'd15;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_ctl = 0; m_a = 0; m_b = 0; m_st = 0; m_rd = 0;
        m_rw = 0; m_mr = 0; m_mw = 0; m_br = 0; m_ill = 0; m_cnt = 0; m_cnt_s = 0;
    endtask

    task automatic model_edge();
        logic accept;
        accept = bus_a.i_valid && (!m_valid || bus_a.i_ready) && !bus_a.i_flush;
        if (m_valid && !bus_a.i_ready && !bus_a.i_flush) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 3) m_cnt_s++;
        end
        if (bus_a.i_flush) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_br = 0; m_ill = 0;
        end else if (accept) begin
            m_valid = 1;
            m_ctl   = ref_ctl(bus_a.i_alu_op, bus_a.i_funct3, bus_a.i_funct7_5, bus_a.i_alu_src);
            m_ill   = (m_ctl == 4'd15);
            m_a     = bus_a.i_rs1_data;
            m_b     = bus_a.i_alu_src ? bus_a.i_imm : bus_a.i_rs2_data;
            m_st    = bus_a.i_rs2_data;
            m_rd    = bus_a.i_rd;
            m_rw    = bus_a.i_reg_write;
            m_mr    = bus_a.i_mem_read;
            m_mw    = bus_a.i_mem_write;
            m_br    = bus_a.i_branch;
        end else if (m_valid && bus_a.i_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"},  bus_a.o_valid,       m_valid);
        check({tag, ".ctl"},    bus_a.o_alu_control, m_ctl);
        check({tag, ".ill"},    bus_a.o_illegal,     m_ill);
        check({tag, ".a"},      bus_a.o_alu_a,       m_a);
        check({tag, ".b"},      bus_a.o_alu_b,       m_b);
        check({tag, ".st"},     bus_a.o_store_data,  m_st);
        check({tag, ".rd"},     bus_a.o_rd,          m_rd);
        check({tag, ".ctrl"},   {bus_a.o_reg_write, bus_a.o_mem_read, bus_a.o_mem_write, bus_a.o_branch},
                                {m_rw, m_mr, m_mw, m_br});
        check({tag, ".cnt"},    bus_a.o_stall_cnt,   m_cnt);
        check({tag, ".cnt2"},   bus_b.o_stall_cnt,   m_cnt_s);
    endtask

    // One clock: check combinational ready, advance the model, then check registered outputs.
    task automatic step(input string tag);
        #1;
        check({tag, ".ready"}, bus_a.o_ready, (!m_valid || bus_a.i_ready));
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                             input logic src, input logic [63:0] rs1, input logic [63:0] rs2,
                             input logic [63:0] imm, input logic [4:0] rd, input logic [3:0] ctrl);
        bus_a.i_alu_op = op; bus_a.i_funct3 = f3; bus_a.i_funct7_5 = f7; bus_a.i_alu_src = src;
        bus_a.i_rs1_data = rs1; bus_a.i_rs2_data = rs2; bus_a.i_imm = imm; bus_a.i_rd = rd;
        {bus_a.i_reg_write, bus_a.i_mem_read, bus_a.i_mem_write, bus_a.i_branch} = ctrl;
    endtask

    task automatic set_hs(input logic v, input logic r, input logic f);
        bus_a.i_valid = v; bus_a.i_ready = r; bus_a.i_flush = f;
    endtask

    task automatic set_rand();
        set_instr(2'($urandom_range(0, 3)), 3'($urandom), 1'($urandom), 1'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  5'($urandom), 4'($urandom));
        set_hs($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        set_hs(1'b1, 1'b1, 1'b0);
        set_instr(2'b10, 3'b000, 1'b0, 1'b0, 64'd5, 64'd7, 64'd0, 5'd1, 4'b1000);

        // Reset held while decode presents an instruction.
        repeat (2) @(posedge clk);
        #1;
        check("rst.ready", bus_a.o_ready, 1'b1);
        check_all("rst");

        rst_n = 1'b1;
        step("add");
        check("add.ctl_lit", bus_a.o_alu_control, 4'b0010);
        check("add.a_lit",   bus_a.o_alu_a, 64'd5);
        check("add.b_lit",   bus_a.o_alu_b, 64'd7);

        set_instr(2'b10, 3'b000, 1'b1, 1'b0, 64'd9, 64'd4, 64'd0, 5'd2, 4'b1000);
        step("sub");
        check("sub.ctl_lit", bus_a.o_alu_control, 4'b0110);
        set_instr(2'b10, 3'b111, 1'b0, 1'b0, 64'hF0, 64'h3C, 64'd0, 5'd3, 4'b1000);
        step("and");
        check("and.ctl_lit", bus_a.o_alu_control, 4'b0000);
        set_instr(2'b10, 3'b110, 1'b0, 1'b0, 64'hF0, 64'h0F, 64'd0, 5'd4, 4'b1000);
        step("or");
        check("or.ctl_lit",   bus_a.o_alu_control, 4'b0001);
        check("or.valid_lit", bus_a.o_valid, 1'b1);

        // I-type addi with bit 30 set must stay add and take the immediate.
        set_instr(2'b10, 3'b000, 1'b1, 1'b1, 64'd100, 64'd55, 64'hFFFF_FFFF_FFFF_FFF0, 5'd5, 4'b1000);
        step("addi");
        check("addi.ctl_lit", bus_a.o_alu_control, 4'b0010);
        check("addi.b_lit",   bus_a.o_alu_b, 64'hFFFF_FFFF_FFFF_FFF0);
        set_instr(2'b00, 3'b011, 1'b1, 1'b1, 64'd200, 64'h1234, 64'hFFFF_FFFF_FFFF_FFF0, 5'd0, 4'b0010);
        step("store");
        check("store.ctl_lit", bus_a.o_alu_control, 4'b0010);
        check("store.st_lit",  bus_a.o_store_data, 64'h1234);

        // Stall three cycles with new data waiting upstream.
        set_instr(2'b01, 3'b000, 1'b0, 1'b0, 64'd77, 64'd88, 64'd0, 5'd6, 4'b0001);
        set_hs(1'b1, 1'b0, 1'b0);
        step("stall1");
        check("stall1.st_lit", bus_a.o_store_data, 64'h1234);
        step("stall2");
        step("stall3");
        #1;
        check("stall3.ready_lit", bus_a.o_ready, 1'b0);
        check("stall3.cnt_lit",   bus_a.o_stall_cnt, 16'd3);
        set_hs(1'b1, 1'b1, 1'b0);
        step("unstall");
        check("unstall.a_lit", bus_a.o_alu_a, 64'd77);

        // Flush a held entry with reg_write set; incoming is dropped.
        set_instr(2'b10, 3'b111, 1'b0, 1'b0, 64'hAA, 64'hBB, 64'd0, 5'd7, 4'b1000);
        step("pre_flush");
        set_instr(2'b10, 3'b110, 1'b0, 1'b0, 64'hCC, 64'hDD, 64'd0, 5'd8, 4'b1000);
        set_hs(1'b1, 1'b0, 1'b1);
        step("flush");
        check("flush.valid_lit", bus_a.o_valid, 1'b0);
        check("flush.rw_lit",    bus_a.o_reg_write, 1'b0);
        check("flush.a_lit",     bus_a.o_alu_a, 64'hAA);
        set_hs(1'b1, 1'b1, 1'b0);
        step("post_flush_load");
        set_hs(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("sat_stall");
        check("sat.cnt2_lit", bus_b.o_stall_cnt, 2'd3);
        check("sat.cnt_lit",  bus_a.o_stall_cnt, 16'd8);

        // Illegal decodes, then a legal op clears the flag.
        set_hs(1'b1, 1'b1, 1'b0);
        set_instr(2'b10, 3'b001, 1'b0, 1'b0, 64'd1, 64'd2, 64'd0, 5'd9, 4'b1000);
        step("ill_f3");
        check("ill_f3.lit", {bus_a.o_illegal, bus_a.o_alu_control}, 5'b1_1111);
        set_instr(2'b11, 3'b000, 1'b0, 1'b0, 64'd1, 64'd2, 64'd0, 5'd9, 4'b1000);
        step("ill_op");
        check("ill_op.lit", {bus_a.o_illegal, bus_a.o_alu_control}, 5'b1_1111);
        set_instr(2'b01, 3'b000, 1'b0, 1'b0, 64'd1, 64'd2, 64'd0, 5'd9, 4'b0001);
        step("legal");
        check("legal.ill_lit", bus_a.o_illegal, 1'b0);

        // Asynchronous reset mid-operation discards the entry without a clock edge.
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst.valid", bus_a.o_valid, 1'b0);
        check_all("async_rst");
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            set_rand();
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
